mesh_host_ctrl: RTL
===================

// Module: mesh_host_ctrl
// PURPOSE
//  Host-side initiator for the systolic mesh top: drives the preload port (preload_valid/addr/data),
//  pulses start, waits for done, captures result_flat and streams it out one row per beat.
//  Takes weights from a valid/ready input stream; sits between host/DMA logic and the mesh top.
// PARAMETERS
//  DW             8   weight width; result row width is 2*DW
//  ROWS           4   mesh rows
//  COLS           4   mesh columns
//  ROW_W          2   row index width (clog2 ROWS)
//  COL_W          2   col index width (clog2 COLS)
//  TO_W           8   watchdog counter width (MESH_HOST_TIMEOUT_EN only)
//  TIMEOUT_CYCLES 200 WAIT cycles before timeout (MESH_HOST_TIMEOUT_EN only)
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous reset, active-high
//  run_req        in   1              pulse: begin a job (honoured in IDLE only)
//  busy           out  1              high in any state except IDLE
//  s_valid        in   1              weight stream valid
//  s_ready        out  1              weight stream ready
//  s_data         in   DW             weight, row-major order (r0c0, r0c1, ...)
//  preload_valid  out  1              to mesh preload port
//  preload_addr   out  ROW_W+COL_W    {row, col}
//  preload_data   out  DW             weight value
//  start          out  1              one-cycle start pulse to mesh
//  mesh_done      in   1              mesh computation complete
//  result_flat_in in   ROWS*2*DW      mesh result; row i = [(i+1)*2*DW-1 -: 2*DW]
//  m_valid        out  1              result stream valid
//  m_ready        in   1              result stream ready
//  m_data         out  2*DW           one row result per beat, row 0 first
//  m_last         out  1              high with row ROWS-1 beat
//  err_timeout    out  1              sticky watchdog flag
// BEHAVIOUR
//  - Single clock clk; rst synchronous active-high. All outputs registered; rst -> state IDLE, every
//    output 0, load/drain counters 0, capture register 0. rst mid-job aborts without further pulses.
//  - FSM: IDLE -> LOAD -> START -> WAIT -> DRAIN -> IDLE.
//  - IDLE: s_ready=0, m_valid=0. run_req=1 -> LOAD, load count k=0. run_req in other states ignored.
//  - LOAD: s_ready=1. Each s_valid&&s_ready handshake: next cycle preload_valid=1,
//    preload_addr={k/COLS, k%COLS}, preload_data=s_data; k++. No handshake -> preload_valid=0 next cycle.
//    Accept of k=ROWS*COLS-1 -> START; s_ready drops the cycle after the final accept.
//  - START: start=1 for exactly one cycle (cycle after the final preload_valid beat) -> WAIT.
//  - WAIT: mesh_done=1 -> capture result_flat_in into shadow reg, row index j=0, -> DRAIN.
//    mesh_done in any other state ignored.
//  - DRAIN: m_valid=1, m_data=shadow[(j+1)*2*DW-1 -: 2*DW], m_last=(j==ROWS-1). Hold m_data stable
//    while m_valid&&!m_ready. On handshake j++; handshake with m_last -> IDLE, m_valid=0 next cycle.
//  - busy = (state != IDLE). Back-to-back jobs allowed: run_req in the IDLE cycle after DRAIN accepted.
//  - Counters: k is clog2(ROWS*COLS) bits, never wraps within a job; j is ROW_W bits.
// CONFIGURATION
//  MESH_HOST_TIMEOUT_EN defined: WAIT counter (TO_W bits) clears on WAIT entry, increments per cycle;
//    reaching TIMEOUT_CYCLES with no mesh_done -> err_timeout=1, -> IDLE, no DRAIN beats.
//    err_timeout sticky; cleared by rst or by the next accepted run_req. mesh_done on the same
//    cycle as expiry wins (normal capture, no error).
//  Not defined: err_timeout tied 0; WAIT lasts indefinitely until mesh_done.
// TESTING
//  1 run_req; stream w[r][c]=r+c+1 with no gaps -> preload_addr 0..15 in order, data 1,2,3,4,2,3,4,5,...,7;
//    start high exactly one cycle, the cycle after the last preload_valid.
//  2 s_valid toggling 1/0 every cycle in LOAD -> preload_valid toggles to match, same 16 addr/data pairs, single start.
//  3 mesh_done with result_flat_in={16'd40,16'd30,16'd20,16'd10}, m_ready=1 -> m_data 10,20,30,40;
//    m_last only on 40; busy low the cycle after.
//  4 m_ready low 3 cycles on beat 1 -> m_data stays 20, m_valid stays 1; no beat lost or duplicated.
//  5 rst asserted after 7 weights accepted -> next cycle all outputs 0, state IDLE; new run_req restarts at addr 0.
//  6 (MESH_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=20) withhold mesh_done -> err_timeout=1 after 20 WAIT cycles,
//    busy=0, m_valid never set; next run_req clears err_timeout.

Source files
------------

// File: rtl/mesh_host_ctrl.sv
// rtl/mesh_host_ctrl.sv - host-side initiator: preload weights, pulse start, wait done, stream result rows
// Optional feature macro: MESH_HOST_TIMEOUT_EN (WAIT-state watchdog driving sticky err_timeout)
module mesh_host_ctrl #(
    parameter int DW             = 8,
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int ROW_W          = 2,
    parameter int COL_W          = 2,
    parameter int TO_W           = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_req,
    output logic                   busy,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DW-1:0]          s_data,
    output logic                   preload_valid,
    output logic [ROW_W+COL_W-1:0] preload_addr,
    output logic [DW-1:0]          preload_data,
    output logic                   start,
    input  logic                   mesh_done,
    input  logic [ROWS*2*DW-1:0]   result_flat_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [2*DW-1:0]        m_data,
    output logic                   m_last,
    output logic                   err_timeout
);
    localparam int NW  = ROWS * COLS;
    localparam int K_W = ROW_W + COL_W;
    localparam int RW  = 2 * DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t              state;
    logic [K_W-1:0]      k;
    logic [ROW_W-1:0]    j;
    logic [ROW_W-1:0]    j_next;
    logic [ROWS*RW-1:0]  shadow;

    assign j_next = j + ROW_W'(1);

`ifdef MESH_HOST_TIMEOUT_EN
    logic [TO_W-1:0]     to_cnt;
`else
    // No watchdog: flag is constant low; the timeout parameters only feed this constant.
    assign err_timeout = 1'b0 & (TIMEOUT_CYCLES < (1 << TO_W));
`endif

    // Job sequencer: every output is a register updated alongside the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            s_ready       <= 1'b0;
            preload_valid <= 1'b0;
            preload_addr  <= '0;
            preload_data  <= '0;
            start         <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_last        <= 1'b0;
            k             <= '0;
            j             <= '0;
            shadow        <= '0;
`ifdef MESH_HOST_TIMEOUT_EN
            to_cnt        <= '0;
            err_timeout   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_req) begin
                        state   <= S_LOAD;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                        k       <= '0;
`ifdef MESH_HOST_TIMEOUT_EN
                        err_timeout <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (s_valid && s_ready) begin
                        preload_valid <= 1'b1;
                        preload_addr  <= {ROW_W'(k / K_W'(COLS)), COL_W'(k % K_W'(COLS))};
                        preload_data  <= s_data;
                        k             <= k + K_W'(1);
                        if (k == K_W'(NW - 1)) begin
                            s_ready <= 1'b0;
                            state   <= S_START;
                        end
                    end else begin
                        preload_valid <= 1'b0;
                    end
                end
                S_START: begin
                    // Entered while the last preload beat is on the bus; start follows it.
                    preload_valid <= 1'b0;
                    start         <= 1'b1;
                    state         <= S_WAIT;
`ifdef MESH_HOST_TIMEOUT_EN
                    to_cnt        <= '0;
`endif
                end
                S_WAIT: begin
                    start <= 1'b0;
                    // mesh_done takes priority over a watchdog expiry in the same cycle.
                    if (mesh_done) begin
                        shadow  <= result_flat_in;
                        j       <= '0;
                        m_valid <= 1'b1;
                        m_data  <= result_flat_in[RW-1:0];
                        m_last  <= (ROWS == 1);
                        state   <= S_DRAIN;
                    end
`ifdef MESH_HOST_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                S_DRAIN: begin
                    // m_data only advances on a handshake, so it holds through back-pressure.
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            j      <= j_next;
                            m_data <= shadow[int'(j_next) * RW +: RW];
                            m_last <= (j_next == ROW_W'(ROWS - 1));
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
